generic_mux_arbiter: RTL
========================

// Module: generic_mux_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer driving the one-hot io_select of GenericMux. Shares the mux's
//  single output channel between N requesters. A grant holds until the owner releases or a
//  hold-time limit preempts it. Select is forced all-zero for a turnaround gap between owners,
//  so the mux never switches directly from one owner to another.
// PARAMETERS
//  N           3   number of requesters / mux inputs (>=2)
//  HOLD_MAX    4   max cycles a grant lasts while others wait; 0 = no preemption
//  GAP_CYCLES  1   all-zero select cycles between grants; 0 = re-arbitrate immediately
// PORTS
//  clock           in   1          single clock, all state on rising edge
//  reset           in   1          synchronous, active-high
//  io_req          in   N          bit i: requester i wants the channel (level)
//  io_release      in   N          bit i: owner i done (pulse); ignored unless i is current owner
//  io_select       out  N          one-hot (or zero) select to GenericMux io_select; registered
//  io_grant_valid  out  1          1 when io_select is non-zero
//  io_grant_idx    out  clog2(N)   index of the current owner; 0 when io_grant_valid=0
//  io_preempt      out  1          one-cycle pulse: current grant removed by HOLD_MAX
// BEHAVIOUR
//  Reset: state=IDLE, io_select=0, io_grant_valid=0, io_grant_idx=0, io_preempt=0, hold_cnt=0,
//   gap_cnt=0, rr_ptr=N-1 (so requester 0 wins first after reset).
//  All outputs registered. A request seen in cycle t gives io_select valid in cycle t+1 at the earliest.
//  Round-robin: winner = first asserted io_req bit scanning rr_ptr+1, rr_ptr+2, ... mod N.
//   rr_ptr <= winner when a grant is issued.
//  FSM:
//   IDLE : no req -> stay. Any req -> BUSY; io_select<=onehot(winner); hold_cnt<=0.
//   BUSY : end = io_release[owner] | ~io_req[owner].
//          pre = (HOLD_MAX!=0) & hold_cnt==HOLD_MAX-1 & (io_req & ~onehot(owner))!=0.
//          end|pre -> io_select<=0; io_preempt<=pre&~end; next = GAP if GAP_CYCLES>0,
//            otherwise re-arbitrate in the same cycle (IDLE rules; owner still eligible by rr order).
//          Neither -> hold; hold_cnt saturates at HOLD_MAX-1 (no wrap).
//   GAP  : io_select=0 for exactly GAP_CYCLES cycles (gap_cnt counts 0..GAP_CYCLES-1), then IDLE rules.
//  Release and preempt in the same cycle: release wins, io_preempt stays 0.
//  io_release bits of non-owners, and any io_release outside BUSY, are ignored.
//  Only the current owner's io_req drop ends a grant. Other req changes only affect the next arbitration.
//  A preempted owner that keeps requesting re-enters arbitration with lowest priority, because
//   rr_ptr still points to it.
//  Reset asserted mid-grant: next cycle all outputs are at reset values, with no gap enforced.
//  io_select is never multi-hot. A bench assertion checks $onehot0(io_select) every cycle.
// STRUCTURE
//  Shared package: state enum {IDLE,BUSY,GAP}, IDX_W=clog2(N), CNT_W=clog2(max(HOLD_MAX,GAP_CYCLES,2)).
//  Sub-module rr_priority_pick (combinational): inputs req[N] and ptr; outputs winner index + found.
//  FSM, counters and output registers live in generic_mux_arbiter.
//  Output io_select connects directly to GenericMux io_select.
// TESTING (N=3, HOLD_MAX=4, GAP_CYCLES=1)
//  1. Reset, io_req=001 at t0 -> io_select=001, idx=0 at t1. Release at t3 -> select=000 at t4.
//  2. io_req=111 constant, no releases -> owners 0,1,2,0 in turn. Each holds 4 cycles,
//     followed by a 1-cycle 000 gap. io_preempt pulses at each handover.
//  3. Only req 2 held, no releases -> select=100 indefinitely, io_preempt never asserts.
//  4. Owner 1 release on the same cycle hold_cnt hits 3 with req0 pending -> io_preempt=0,
//     gap, then select=001.
//  5. io_release=100 while owner is 0 -> ignored, select stays 001. Owner drops io_req -> grant ends.
//  6. Reset during BUSY with select=010 -> next cycle select=000, valid=0. After reset, with
//     io_req=110, the first grant goes to 1.

Source files
------------

// File: rtl/generic_mux_arbiter_pkg.sv
// Shared types and sizing helpers for the GenericMux round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_*       : default parameter values used by the top module
//   idx_width() : width of a requester index, clog2(N)
//   cnt_width() : width of the hold/gap counters, clog2(max(HOLD_MAX, GAP_CYCLES, 2))
package generic_mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      GAP
   } arb_state_e;

   localparam int DEF_N          = 3;
   localparam int DEF_HOLD_MAX   = 4;
   localparam int DEF_GAP_CYCLES = 1;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_width(input int hold_max, input int gap_cycles);
      int m;
      m = 2;
      if (hold_max > m) m = hold_max;
      if (gap_cycles > m) m = gap_cycles;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/generic_mux_arbiter_pick.sv
// Combinational round-robin pick.
//   req    : request vector, bit i = requester i
//   ptr    : index of the previous winner; scanning starts at ptr+1
//   winner : first asserted req bit in the order ptr+1, ptr+2, ... (mod N)
//   found  : 1 when any req bit is asserted
module rr_priority_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             found
);

   int               pos;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      pos    = 0;
      cand   = '0;
      // k runs 1..N so the previous winner itself is examined last.
      for (int k = 1; k <= N; k++) begin
         pos  = (int'(ptr) + k) % N;
         cand = IDX_W'(pos);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/generic_mux_arbiter.sv
// Round-robin arbiter driving the one-hot io_select of GenericMux.
// A grant holds until the owner releases (or drops its request) or, while others
// wait, until HOLD_MAX cycles have elapsed. Select is forced to zero for
// GAP_CYCLES cycles between owners so the mux never switches owner-to-owner.
//   clock, reset   : single clock; synchronous active-high reset
//   io_req         : per-requester level request
//   io_release     : per-requester done pulse, honoured only for the current owner
//   io_select      : registered one-hot (or zero) mux select
//   io_grant_valid : io_select is non-zero
//   io_grant_idx   : index of the current owner, 0 when no grant
//   io_preempt     : one-cycle pulse when a grant was removed by the hold limit
module generic_mux_arbiter
   import generic_mux_arbiter_pkg::*;
#(
   parameter  int N          = DEF_N,
   parameter  int HOLD_MAX   = DEF_HOLD_MAX,
   parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
   localparam int IDX_W      = idx_width(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     io_req,
   input  logic [N-1:0]     io_release,
   output logic [N-1:0]     io_select,
   output logic             io_grant_valid,
   output logic [IDX_W-1:0] io_grant_idx,
   output logic             io_preempt
);

   localparam int               CNT_W     = cnt_width(HOLD_MAX, GAP_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(N - 1);
   localparam logic [N-1:0]     ONE       = {{(N-1){1'b0}}, 1'b1};

   arb_state_e       state_q, state_d;
   logic [N-1:0]     select_q, select_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             preempt_q, preempt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [IDX_W-1:0] rr_q, rr_d;

   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic [N-1:0]     win_oh;
   logic [N-1:0]     owner_oh;
   logic             grant_end;
   logic             grant_pre;
   logic             do_arb;

   rr_priority_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (io_req),
      .ptr    (rr_q),
      .winner (win_idx),
      .found  (win_found)
   );

   assign win_oh   = ONE << win_idx;
   assign owner_oh = ONE << idx_q;

   // Only the owner's own release or request drop ends a grant; other bits are don't-care.
   assign grant_end = (|(io_release & owner_oh)) | ~(|(io_req & owner_oh));
   assign grant_pre = (HOLD_MAX != 0) && (hold_q == HOLD_LAST) && (|(io_req & ~owner_oh));

   // NOTE: every signal driven here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      select_d  = select_q;
      idx_d     = idx_q;
      preempt_d = 1'b0;
      hold_d    = hold_q;
      gap_d     = gap_q;
      rr_d      = rr_q;
      do_arb    = 1'b0;

      case (state_q)
         IDLE: do_arb = 1'b1;

         BUSY: begin
            if (grant_end || grant_pre) begin
               select_d  = '0;
               idx_d     = '0;
               // A release in the same cycle as the limit is a normal end, not a preemption.
               preempt_d = grant_pre & ~grant_end;
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  do_arb = 1'b1;
               end
            end else if (HOLD_MAX != 0 && hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
         end

         GAP: begin
            if (gap_q == GAP_LAST) do_arb = 1'b1;
            else                   gap_d  = gap_q + 1'b1;
         end

         default: state_d = IDLE;
      endcase

      // Arbitration overrides select/idx; a preempt pulse computed above is kept.
      if (do_arb) begin
         state_d = IDLE;
         if (win_found) begin
            state_d  = BUSY;
            select_d = win_oh;
            idx_d    = win_idx;
            hold_d   = '0;
            rr_d     = win_idx;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         select_q  <= '0;
         idx_q     <= '0;
         preempt_q <= 1'b0;
         hold_q    <= '0;
         gap_q     <= '0;
         rr_q      <= PTR_INIT;
      end else begin
         state_q   <= state_d;
         select_q  <= select_d;
         idx_q     <= idx_d;
         preempt_q <= preempt_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         rr_q      <= rr_d;
      end
   end

   assign io_select      = select_q;
   assign io_grant_valid = |select_q;
   assign io_grant_idx   = idx_q;
   assign io_preempt     = preempt_q;

endmodule
